avalon_mm_arbiter: RTL and testbench

//  Two-host to one-agent Avalon-MM arbiter in front of the f2h SDRAM port. Host 0 = video

---
 rtl/avalon_mm_arbiter_if.sv | 26 ++
 rtl/avalon_mm_arbiter.sv | 117 +++++++++++
 tb/tb_avalon_mm_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_mm_arbiter_if.sv
// rtl/avalon_mm_arbiter_if.sv - one Avalon-MM burst link (host or agent side)
interface avalon_mm_arbiter_if #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int BCW = 6
);
  logic [AW-1:0]   address;
  logic [BCW-1:0]  burstcount;
  logic            read;
  logic            write;
  logic [DW-1:0]   writedata;
  logic [DW/8-1:0] byteenable;
  logic            waitrequest;
  logic [DW-1:0]   readdata;
  logic            readdatavalid;

  modport master (
    output address, burstcount, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avalon_mm_arbiter.sv
// rtl/avalon_mm_arbiter.sv - two-host to one-agent Avalon-MM burst arbiter
// Grants whole bursts, one transaction in flight, read beats routed to the owner only.
module avalon_mm_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int BCW     = 6,
  parameter bit H0_PRIO = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  avalon_mm_arbiter_if.slave  h0,
  avalon_mm_arbiter_if.slave  h1,
  avalon_mm_arbiter_if.master a,
  output logic [1:0]          grant
);
  typedef enum logic [1:0] {IDLE, RD_CMD, WR_BURST, RD_DATA} state_t;

  localparam logic [BCW-1:0] ONE = BCW'(1);

  state_t         state;
  logic           rr_next;
  logic           a_read_q;
  logic [AW-1:0]  addr_q;
  logic [BCW-1:0] bc_q;
  logic [BCW-1:0] beats;

  logic           req0, req1, pick1, pick_read, own1, own_write;
  logic           wr_accept, rd_beat, wait_fwd;
  logic [BCW-1:0] pick_bc, pick_len;

  assign req0      = h0.read | h0.write;
  assign req1      = h1.read | h1.write;
  // rr_next names the host that wins the next tie (loser of the previous tie)
  assign pick1     = req1 & (~req0 | (~H0_PRIO & rr_next));
  assign pick_read = pick1 ? h1.read : h0.read;
  assign pick_bc   = pick1 ? h1.burstcount : h0.burstcount;
  assign pick_len  = (pick_bc == '0) ? ONE : pick_bc;

  assign own1      = grant[1];
  assign own_write = own1 ? h1.write : h0.write;
  assign wr_accept = (state == WR_BURST) && own_write && !a.waitrequest;
  assign rd_beat   = (state == RD_DATA) && a.readdatavalid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      grant    <= 2'b00;
      rr_next  <= 1'b0;
      a_read_q <= 1'b0;
      addr_q   <= '0;
      bc_q     <= '0;
      beats    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant  <= pick1 ? 2'b10 : 2'b01;
            addr_q <= pick1 ? h1.address : h0.address;
            bc_q   <= pick_len;
            beats  <= pick_len;
            if (req0 && req1 && !H0_PRIO)
              rr_next <= ~pick1;
            if (pick_read) begin
              state    <= RD_CMD;
              a_read_q <= 1'b1;
            end else begin
              state <= WR_BURST;
            end
          end
        end
        RD_CMD: begin
          if (!a.waitrequest) begin
            a_read_q <= 1'b0;
            state    <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (a.readdatavalid) begin
            beats <= beats - ONE;
            if (beats == ONE) begin
              state <= IDLE;
              grant <= 2'b00;
            end
          end
        end
        WR_BURST: begin
          if (wr_accept) begin
            beats <= beats - ONE;
            if (beats == ONE) begin
              state <= IDLE;
              grant <= 2'b00;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address and burstcount come from the first beat; data follows the owner live.
  assign a.address    = addr_q;
  assign a.burstcount = bc_q;
  assign a.read       = a_read_q;
  assign a.write      = (state == WR_BURST) && own_write;
  assign a.writedata  = own1 ? h1.writedata : h0.writedata;
  assign a.byteenable = own1 ? h1.byteenable : h0.byteenable;

  // No new command can be accepted while read beats are still returning.
  assign wait_fwd = ((state == RD_CMD) || (state == WR_BURST)) ? a.waitrequest : 1'b1;

  assign h0.waitrequest   = grant[0] ? wait_fwd : 1'b1;
  assign h1.waitrequest   = grant[1] ? wait_fwd : 1'b1;
  assign h0.readdata      = a.readdata;
  assign h1.readdata      = a.readdata;
  assign h0.readdatavalid = rd_beat && grant[0];
  assign h1.readdatavalid = rd_beat && grant[1];
endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// tb/tb_avalon_mm_arbiter.sv - directed self-checking bench for avalon_mm_arbiter
module tb_avalon_mm_arbiter;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] grant;
  logic [1:0] rr_grant;
  int         checks = 0;
  int         errors = 0;

  avalon_mm_arbiter_if #(.AW(32), .DW(32), .BCW(6)) h0();
  avalon_mm_arbiter_if #(.AW(32), .DW(32), .BCW(6)) h1();
  avalon_mm_arbiter_if #(.AW(32), .DW(32), .BCW(6)) ag();
  avalon_mm_arbiter_if #(.AW(32), .DW(32), .BCW(6)) r0();
  avalon_mm_arbiter_if #(.AW(32), .DW(32), .BCW(6)) r1();
  avalon_mm_arbiter_if #(.AW(32), .DW(32), .BCW(6)) ra();

  avalon_mm_arbiter #(.AW(32), .DW(32), .BCW(6), .H0_PRIO(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .h0(h0), .h1(h1), .a(ag), .grant(grant)
  );

  avalon_mm_arbiter #(.AW(32), .DW(32), .BCW(6), .H0_PRIO(1'b0)) dut_rr (
    .clk(clk), .reset_n(reset_n), .h0(r0), .h1(r1), .a(ra), .grant(rr_grant)
  );

  always #5 clk = ~clk;

  task automatic init_inputs();
    h0.address = '0; h0.burstcount = '0; h0.read = 0; h0.write = 0; h0.writedata = '0; h0.byteenable = '0;
    h1.address = '0; h1.burstcount = '0; h1.read = 0; h1.write = 0; h1.writedata = '0; h1.byteenable = '0;
    r0.address = '0; r0.burstcount = 6'd1; r0.read = 0; r0.write = 0; r0.writedata = '0; r0.byteenable = '0;
    r1.address = '0; r1.burstcount = 6'd1; r1.read = 0; r1.write = 0; r1.writedata = '0; r1.byteenable = '0;
    ag.waitrequest = 1; ag.readdata = '0; ag.readdatavalid = 0;
    ra.waitrequest = 0; ra.readdata = '0; ra.readdatavalid = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    ag.readdatavalid = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
    checks++; if (rr_grant !== 2'b00) begin errors++; $display("FAIL reset_rr_grant got %b exp 00", rr_grant); end
    checks++; if (ag.read !== 1'b0 || ag.write !== 1'b0) begin errors++; $display("FAIL reset_a_cmd got rd=%b wr=%b exp 0 0", ag.read, ag.write); end
    checks++; if (h0.waitrequest !== 1'b1 || h1.waitrequest !== 1'b1) begin errors++; $display("FAIL reset_waitreq got %b %b exp 1 1", h0.waitrequest, h1.waitrequest); end
    checks++; if (h0.readdatavalid !== 1'b0 || h1.readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv got %b %b exp 0 0", h0.readdatavalid, h1.readdatavalid); end
    @(negedge clk);
    ag.readdatavalid = 0;
    reset_n = 1;
  endtask

  task automatic test_read_burst();
    logic [31:0] exp_data;
    @(negedge clk);
    h0.read = 1; h0.address = 32'h0000_1000; h0.burstcount = 6'd8; ag.waitrequest = 1;
    #1;
    checks++; if (grant !== 2'b00 || h0.waitrequest !== 1'b1) begin errors++; $display("FAIL rd_idle got grant=%b wait=%b exp 00 1", grant, h0.waitrequest); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ag.waitrequest = (i == 2) ? 1'b0 : 1'b1;
      #1;
      checks++; if (grant !== 2'b01 || ag.read !== 1'b1) begin errors++; $display("FAIL rd_cmd%0d got grant=%b a_read=%b exp 01 1", i, grant, ag.read); end
      checks++; if (h0.waitrequest !== ag.waitrequest || h1.waitrequest !== 1'b1) begin errors++; $display("FAIL rd_wait%0d got %b %b exp %b 1", i, h0.waitrequest, h1.waitrequest, (i == 2) ? 1'b0 : 1'b1); end
      checks++; if (ag.address !== 32'h0000_1000 || ag.burstcount !== 6'd8) begin errors++; $display("FAIL rd_addr%0d got %h/%0d exp 1000/8", i, ag.address, ag.burstcount); end
    end
    @(negedge clk);
    h0.read = 0;
    #1;
    checks++; if (ag.read !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL rd_drop got a_read=%b grant=%b exp 0 01", ag.read, grant); end
    repeat (3) begin
      @(negedge clk); #1;
      checks++; if (h0.readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_latency got rdv=%b exp 0", h0.readdatavalid); end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_data = 32'hD000_0000 + i;
      ag.readdatavalid = 1; ag.readdata = exp_data;
      #1;
      checks++; if (h0.readdatavalid !== 1'b1 || h0.readdata !== exp_data) begin errors++; $display("FAIL rd_beat%0d got rdv=%b data=%h exp 1 %h", i, h0.readdatavalid, h0.readdata, exp_data); end
      checks++; if (h1.readdatavalid !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL rd_other%0d got h1rdv=%b grant=%b exp 0 01", i, h1.readdatavalid, grant); end
    end
    @(negedge clk);
    ag.readdatavalid = 0;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rd_end_grant got %b exp 00", grant); end
  endtask

  task automatic test_write_burst();
    logic        wr_seq   [6] = '{1, 1, 0, 1, 1, 1};
    logic [31:0] dat_seq  [6] = '{32'hA0, 32'hA1, 32'hA1, 32'hA2, 32'hA2, 32'hA3};
    logic        wait_seq [6] = '{0, 0, 0, 1, 0, 0};
    logic [31:0] exp_beat [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    int k = 0;
    @(negedge clk);
    h1.write = 1; h1.address = 32'h0000_2000; h1.burstcount = 6'd4; h1.writedata = 32'hA0; h1.byteenable = 4'hF;
    ag.waitrequest = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      h1.write = wr_seq[i]; h1.writedata = dat_seq[i]; ag.waitrequest = wait_seq[i];
      if (i == 1) h1.address = 32'h0000_9999;
      #1;
      checks++; if (grant !== 2'b10 || h0.waitrequest !== 1'b1) begin errors++; $display("FAIL wr_grant%0d got %b h0wait=%b exp 10 1", i, grant, h0.waitrequest); end
      checks++; if (ag.write !== wr_seq[i] || h1.waitrequest !== wait_seq[i]) begin errors++; $display("FAIL wr_strobe%0d got wr=%b wait=%b exp %b %b", i, ag.write, h1.waitrequest, wr_seq[i], wait_seq[i]); end
      checks++; if (ag.address !== 32'h0000_2000 || ag.burstcount !== 6'd4) begin errors++; $display("FAIL wr_addr%0d got %h/%0d exp 2000/4", i, ag.address, ag.burstcount); end
      if (ag.write && !ag.waitrequest && k < 4) begin
        checks++; if (ag.writedata !== exp_beat[k]) begin errors++; $display("FAIL wr_data%0d got %h exp %h", k, ag.writedata, exp_beat[k]); end
        k++;
      end
    end
    @(negedge clk);
    h1.write = 0;
    #1;
    checks++; if (k !== 4) begin errors++; $display("FAIL wr_count got %0d exp 4", k); end
    checks++; if (grant !== 2'b00 || ag.write !== 1'b0) begin errors++; $display("FAIL wr_end got grant=%b wr=%b exp 00 0", grant, ag.write); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    h0.read = 1; h0.burstcount = 6'd1; h1.read = 1; h1.burstcount = 6'd1; ag.waitrequest = 0;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01 || h1.waitrequest !== 1'b1) begin errors++; $display("FAIL prio_first got grant=%b h1wait=%b exp 01 1", grant, h1.waitrequest); end
    @(negedge clk);
    h0.read = 0; ag.readdatavalid = 1; ag.readdata = 32'h0000_00B0;
    #1;
    checks++; if (h0.readdatavalid !== 1'b1 || h1.readdatavalid !== 1'b0) begin errors++; $display("FAIL prio_rdv0 got %b %b exp 1 0", h0.readdatavalid, h1.readdatavalid); end
    @(negedge clk);
    ag.readdatavalid = 0;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL prio_gap got %b exp 00", grant); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b10 || ag.read !== 1'b1) begin errors++; $display("FAIL prio_second got grant=%b a_read=%b exp 10 1", grant, ag.read); end
    @(negedge clk);
    h1.read = 0; ag.readdatavalid = 1;
    #1;
    checks++; if (h1.readdatavalid !== 1'b1 || h0.readdatavalid !== 1'b0) begin errors++; $display("FAIL prio_rdv1 got %b %b exp 1 0", h1.readdatavalid, h0.readdatavalid); end
    @(negedge clk);
    ag.readdatavalid = 0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_order [4] = '{2'b01, 2'b10, 2'b10, 2'b01};
    logic [1:0] g;
    int idx = 0;
    for (int round = 0; round < 2; round++) begin
      r0.read = 1; r1.read = 1;
      for (int t = 0; t < 2; t++) begin
        @(negedge clk); #1;
        g = rr_grant;
        checks++; if (g !== exp_order[idx]) begin errors++; $display("FAIL rr_order%0d got %b exp %b", idx, g, exp_order[idx]); end
        idx++;
        @(negedge clk);
        if (g[0]) r0.read = 0;
        if (g[1]) r1.read = 0;
        ra.readdatavalid = 1;
        #1;
        checks++; if ({r1.readdatavalid, r0.readdatavalid} !== g) begin errors++; $display("FAIL rr_rdv%0d got %b exp %b", idx, {r1.readdatavalid, r0.readdatavalid}, g); end
        @(negedge clk);
        ra.readdatavalid = 0;
      end
    end
    r0.read = 0; r1.read = 0;
  endtask

  task automatic test_no_preempt();
    @(negedge clk);
    h0.read = 1; h0.burstcount = 6'd2; h0.address = 32'h0000_4000; ag.waitrequest = 0;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL np_grant0 got %b exp 01", grant); end
    @(negedge clk);
    h0.read = 0; h1.read = 1; h1.burstcount = 6'd1; h1.address = 32'h0000_3000; ag.readdatavalid = 1;
    #1;
    checks++; if (h1.waitrequest !== 1'b1 || h1.readdatavalid !== 1'b0 || h0.readdatavalid !== 1'b1) begin errors++; $display("FAIL np_beat0 got h1wait=%b h1rdv=%b h0rdv=%b exp 1 0 1", h1.waitrequest, h1.readdatavalid, h0.readdatavalid); end
    @(negedge clk);
    ag.readdatavalid = 0;
    #1;
    checks++; if (h1.waitrequest !== 1'b1 || grant !== 2'b01) begin errors++; $display("FAIL np_gap got h1wait=%b grant=%b exp 1 01", h1.waitrequest, grant); end
    @(negedge clk);
    ag.readdatavalid = 1;
    #1;
    checks++; if (h1.waitrequest !== 1'b1 || h1.readdatavalid !== 1'b0) begin errors++; $display("FAIL np_last got h1wait=%b h1rdv=%b exp 1 0", h1.waitrequest, h1.readdatavalid); end
    @(negedge clk);
    ag.readdatavalid = 0;
    #1;
    checks++; if (grant !== 2'b00 || ag.read !== 1'b0 || h1.waitrequest !== 1'b1) begin errors++; $display("FAIL np_idle got grant=%b a_read=%b h1wait=%b exp 00 0 1", grant, ag.read, h1.waitrequest); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b10 || ag.read !== 1'b1 || ag.address !== 32'h0000_3000 || h1.waitrequest !== 1'b0) begin errors++; $display("FAIL np_h1cmd got grant=%b a_read=%b addr=%h h1wait=%b exp 10 1 3000 0", grant, ag.read, ag.address, h1.waitrequest); end
    @(negedge clk);
    h1.read = 0; ag.readdatavalid = 1;
    #1;
    checks++; if (h1.readdatavalid !== 1'b1 || h0.readdatavalid !== 1'b0) begin errors++; $display("FAIL np_h1beat got %b %b exp 1 0", h1.readdatavalid, h0.readdatavalid); end
    @(negedge clk);
    ag.readdatavalid = 0;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL np_end got %b exp 00", grant); end
  endtask

  task automatic test_burstcount_zero();
    @(negedge clk);
    h0.write = 1; h0.burstcount = 6'd0; h0.address = 32'h0000_5000; h0.writedata = 32'h55; h0.byteenable = 4'h3;
    ag.waitrequest = 0;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01 || ag.write !== 1'b1 || ag.burstcount !== 6'd1) begin errors++; $display("FAIL bc0_cmd got grant=%b wr=%b bc=%0d exp 01 1 1", grant, ag.write, ag.burstcount); end
    checks++; if (ag.writedata !== 32'h55 || ag.byteenable !== 4'h3) begin errors++; $display("FAIL bc0_data got %h/%h exp 55/3", ag.writedata, ag.byteenable); end
    @(negedge clk);
    h0.write = 0;
    #1;
    checks++; if (grant !== 2'b00 || ag.write !== 1'b0) begin errors++; $display("FAIL bc0_end got grant=%b wr=%b exp 00 0", grant, ag.write); end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    h0.read = 1; h0.burstcount = 6'd8; h0.address = 32'h0000_6000; ag.waitrequest = 0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      h0.read = 0; ag.readdatavalid = 1;
      #1;
      checks++; if (h0.readdatavalid !== 1'b1) begin errors++; $display("FAIL rst_beat%0d got %b exp 1", i, h0.readdatavalid); end
    end
    @(negedge clk);
    reset_n = 0;
    #1;
    checks++; if (grant !== 2'b00 || h0.readdatavalid !== 1'b0 || ag.read !== 1'b0) begin errors++; $display("FAIL rst_now got grant=%b rdv=%b a_read=%b exp 00 0 0", grant, h0.readdatavalid, ag.read); end
    checks++; if (h0.waitrequest !== 1'b1 || h1.waitrequest !== 1'b1) begin errors++; $display("FAIL rst_wait got %b %b exp 1 1", h0.waitrequest, h1.waitrequest); end
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (h0.readdatavalid !== 1'b0 || h1.readdatavalid !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL rst_stray%0d got %b %b grant=%b exp 0 0 00", i, h0.readdatavalid, h1.readdatavalid, grant); end
    end
    ag.readdatavalid = 0;
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_read_burst();
    test_write_burst();
    test_priority();
    test_round_robin();
    test_no_preempt();
    test_burstcount_zero();
    test_reset_mid_burst();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
